// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU unit
// producing HI/LO, one radix-2 step per clock.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        sa;
  logic        sb;
  logic        dz;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [63:0] acc;

  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_sh;
  logic [32:0] div_diff;
  logic [63:0] div_next;
  logic        neg;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] hi_fix;
  logic [31:0] lo_fix;

  assign busy = (state != IDLE);

  // operand magnitudes, one datapath step, and final sign fix-up
  always_comb begin
    sgn      = ~op[0];
    a_neg    = sgn & a[31];
    b_neg    = sgn & b[31];
    abs_a    = a_neg ? (~a + 32'd1) : a;
    abs_b    = b_neg ? (~b + 32'd1) : b;
    mul_sum  = {1'b0, acc[63:32]}
             + (acc[0] ? {1'b0, ua} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
    div_sh   = {acc[63:32], acc[31]};
    div_diff = div_sh - {1'b0, ub};
    div_next = div_diff[32]
             ? {div_sh[31:0], acc[30:0], 1'b0}
             : {div_diff[31:0], acc[30:0], 1'b1};
    neg      = sa ^ sb;
    prod     = neg ? (~acc + 64'd1) : acc;
    quo      = dz ? 32'hFFFF_FFFF
             : (neg ? (~acc[31:0] + 32'd1)
                    : acc[31:0]);
    rem      = sa ? (~acc[63:32] + 32'd1)
                  : acc[63:32];
    hi_fix   = is_div ? rem : prod[63:32];
    lo_fix   = is_div ? quo : prod[31:0];
  end

  // control FSM, datapath registers and HI/LO
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz     <= 1'b0;
      ua     <= 32'd0;
      ub     <= 32'd0;
      acc    <= 64'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            sa     <= a_neg;
            sb     <= b_neg;
            dz     <= (b == 32'd0);
            ua     <= abs_a;
            ub     <= abs_b;
            cnt    <= 5'd0;
            acc    <= op[1] ? {32'd0, abs_a}
                            : {32'd0, abs_b};
            state  <= CALC;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          hi    <= hi_fix;
          lo    <= lo_fix;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed + random checks of mul_div_unit
// against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .resetn(resetn),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o,
                                input logic [31:0] x,
                                input logic [31:0] y,
                                output logic [31:0] h,
                                output logic [31:0] l);
    logic signed [63:0] sp;
    logic [63:0] up;
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    sx = x;
    sy = y;
    h = 32'd0;
    l = 32'd0;
    case (o)
      2'd0: begin
        sp = $signed({{32{x[31]}}, x})
           * $signed({{32{y[31]}}, y});
        h = sp[63:32];
        l = sp[31:0];
      end
      2'd1: begin
        up = {32'd0, x} * {32'd0, y};
        h = up[63:32];
        l = up[31:0];
      end
      2'd2: begin
        if (y == 32'd0) begin
          h = x;
          l = 32'hFFFF_FFFF;
        end else if (x == 32'h8000_0000 &&
                     y == 32'hFFFF_FFFF) begin
          h = 32'd0;
          l = 32'h8000_0000;
        end else begin
          sq = sx / sy;
          sr = sx % sy;
          h = sr;
          l = sq;
        end
      end
      default: begin
        if (y == 32'd0) begin
          h = x;
          l = 32'hFFFF_FFFF;
        end else begin
          h = x % y;
          l = x / y;
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input bit disturb,
                        input bit with_move,
                        input string tag);
    logic [31:0] eh;
    logic [31:0] el;
    int cyc;
    bit hold;
    model(o, x, y, eh, el);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    mthi  = with_move;
    mtlo  = with_move;
    wdata = 32'hCAFE_F00D;
    @(posedge clock); #1;
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
    chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    cyc  = 0;
    hold = 1'b1;
    while (busy && cyc < 40) begin
      if (disturb && cyc == 5) begin
        start = 1'b1;
        op    = 2'd1;
        a     = 32'd11;
        b     = 32'd13;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
      end
      if (hi !== cur_hi || lo !== cur_lo) hold = 1'b0;
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    chk({tag, "_lat"}, 32'(cyc), 32'd33);
    chk({tag, "_hold"}, {31'd0, hold}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    cur_hi = eh;
    cur_lo = el;
    @(posedge clock); #1;
    chk({tag, "_done1"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    resetn = 1'b0;
    start  = 1'b0;
    op     = 2'd0;
    a      = 32'd0;
    b      = 32'd0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    wdata  = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    resetn = 1'b1;
    @(posedge clock); #1;

    run_op(2'd1, 32'd7, 32'd6, 0, 0, "multu7x6");
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           0, 0, "mult_m1");
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           0, 0, "multu_ff");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_m7");
    run_op(2'd3, 32'd100, 32'd7, 0, 0, "divu100");
    run_op(2'd3, 32'd5, 32'd0, 0, 0, "divu_z");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd0, 0, 0, "div_z");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF,
           0, 0, "div_ovf");
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000,
           0, 0, "mult_min");
    run_op(2'd2, 32'd1234567, 32'hFFFF_FFF3,
           1, 0, "div_intlk");
    run_op(2'd1, 32'h0001_0003, 32'd9, 0, 1, "mv_drop");

    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'h1234_5678;
    @(posedge clock); #1;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    wdata = 32'd0;
    cur_hi = 32'h1234_5678;
    cur_lo = 32'h1234_5678;
    chk("mt_hi", hi, cur_hi);
    chk("mt_lo", lo, cur_lo);

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom);
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 3) == 0)
        ry = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0)
        rx = 32'($urandom_range(0, 200));
      run_op(ro, rx, ry, 0, 0, "rand");
    end

    start = 1'b1;
    op    = 2'd1;
    a     = 32'd1000;
    b     = 32'd1000;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;
    run_op(2'd1, 32'd3, 32'd3, 0, 0, "multu3x3");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit alongside the ALU in the execute stage of the CPU. It takes the same register operands the ALU receives and produces the 64-bit HI/LO results for MULT/MULTU/DIV/DIVU. HI/LO feed the write-back mux for MFHI/MFLO. The control unit stalls the pipeline on `busy`.

## Interface
- `WIDTH`, 32: operand width. Only 32 is supported.
- `clock` input 1: single clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `start` input 1: start an operation; sampled only in IDLE.
- `op` input 2: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a` input 32: rs operand (multiplicand / dividend).
- `b` input 32: rt operand (multiplier / divisor).
- `mthi` input 1: write `wdata` into HI; honoured only in IDLE.
- `mtlo` input 1: write `wdata` into LO; honoured only in IDLE.
- `wdata` input 32: data for MTHI/MTLO.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse; HI/LO just updated by an operation.
- `hi` output 32: HI register (product[63:32] / remainder).
- `lo` output 32: LO register (product[31:0] / quotient).

## Operation
- **FSM states:** IDLE, CALC, FIX.
- **IDLE, `start`=1:** latch `op`, |a|, |b| and the sign flags (signed ops only), clear the 5-bit iteration counter, go to CALC.
- **CALC:** one radix-2 step per clock, 32 steps, then go to FIX.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit partial remainder and quotient.
- **FIX:** apply sign correction, write HI/LO, pulse `done`, return to IDLE.
- **Signed multiply:** product negated if sign(a) XOR sign(b).
- **Signed divide:** quotient negated if sign(a) XOR sign(b). Remainder takes the sign of the dividend. Truncation toward zero.
- **Arithmetic width:** all internal arithmetic is 64-bit (multiply) or 33-bit (divide subtract). Results are exact with no saturation.
- **Divide by zero (b=0), both DIV and DIVU:** lo=32'hFFFFFFFF, hi=a. The operation still takes the full latency.
- **Signed overflow (DIV, a=32'h80000000, b=32'hFFFFFFFF):** lo=32'h80000000, hi=0.
- **`start` while not IDLE:** ignored. No queueing.
- **`mthi`/`mtlo` while not IDLE:** ignored. In IDLE they write on the clock edge. Both may be asserted in the same cycle.
- **`start` together with `mthi`/`mtlo` in IDLE:** the operation wins and the move is dropped.
- **Operand changes:** `a`, `b` and `op` may change after the start edge without affecting the result.

## Timing
- **Reset (`resetn`=0, any time including mid-operation):** immediately state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. The partial result is discarded.
- **Edge 0:** the edge where `start` is sampled in IDLE. `busy`=1 from after edge 0.
- **Edges 1..32:** CALC iterations.
- **Edge 33:** FIX. HI/LO are updated. After edge 33, `busy`=0 and `done`=1 for exactly one cycle.
- **Latency:** 33 cycles of `busy`. New HI/LO are visible in the cycle after edge 33.
- **Back-to-back:** a new `start` is accepted in the cycle `done` is high, i.e. IDLE is re-entered at edge 33.
- **Outputs:** `hi`/`lo` are registered and change only at edge 33 or on an IDLE move. They hold their old value throughout CALC.

## Test plan
- **MULTU 7×6:** `hi`=0, `lo`=42 after edge 33; `busy` high for exactly 33 cycles; `done` a single pulse.
- **MULT 32'hFFFFFFFF×32'hFFFFFFFF:** hi=0, lo=1. **MULTU** with the same operands: hi=32'hFFFFFFFE, lo=32'h00000001.
- **DIV −7/2:** lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. **DIVU 100/7:** lo=14, hi=2.
- **DIVU 5/0:** lo=32'hFFFFFFFF, hi=5. **DIV 32'h80000000/32'hFFFFFFFF:** lo=32'h80000000, hi=0.
- **Interlocks during CALC:** `start` with new operands, and `mthi`/`mtlo` with wdata=32'hDEADBEEF, are both ignored; the original result is delivered. In IDLE, `mthi`+`mtlo` with wdata=32'h12345678 sets both hi and lo to 32'h12345678 at the next edge.
- **Reset mid-operation:** pull `resetn` low at CALC iteration 10, between clock edges. `busy`, `hi` and `lo` go to 0 immediately with no clock. After release, a new MULTU 3×3 gives lo=9 with full 33-cycle latency.
